// File: rtl/video_write_seq.sv
// video_write_seq: burst/fill write sequencer feeding the video engine write port
module video_write_seq #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_param,
  input  logic [10:0] cmd_index,
  input  logic [10:0] cmd_count,
  input  logic        cmd_fill,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [15:0] data_val,
  output logic        wen,
  output logic [1:0]  w_param,
  output logic [10:0] w_index,
  output logic [15:0] w_val,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BURST, FILL_LOAD, FILL} state_t;
  state_t state;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [1:0] param;
  logic [10:0] idx, rem, limit;
  logic [15:0] fill_val, head, wv;
  logic clip, full, empty, push, pop, emit, in_range;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign data_ready = !full;
  assign push = data_valid && !full;
  assign head = mem[rp[AW-1:0]];
  assign pop = (state == BURST || state == FILL_LOAD) && !empty;
  assign emit = (state == BURST && !empty) || state == FILL;
  assign wv = state == FILL ? fill_val : head;
  assign limit = param == 2'd0 ? 11'd16 : param == 2'd1 ? 11'd256 : 11'd1200;
  assign in_range = idx < limit;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= data_val;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      clip <= 1'b0;
      wen <= 1'b0;
      err <= 1'b0;
      w_param <= '0;
      w_index <= '0;
      w_val <= '0;
      param <= '0;
      idx <= '0;
      rem <= '0;
      fill_val <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      wen <= emit && in_range;
      err <= emit && !in_range && !clip;
      if (emit && in_range) begin
        w_param <= param;
        w_index <= idx;
        w_val <= wv;
      end
      // clip flag deliberately survives index wrap so err fires once per command
      if (emit) begin
        idx <= idx + 11'd1;
        rem <= rem - 11'd1;
        if (!in_range) clip <= 1'b1;
        if (rem == 11'd1) state <= IDLE;
      end
      if (state == IDLE && cmd_valid && cmd_count != '0) begin
        param <= cmd_param;
        idx <= cmd_index;
        rem <= cmd_count;
        clip <= 1'b0;
        state <= cmd_fill ? FILL_LOAD : BURST;
      end
      if (state == FILL_LOAD && !empty) begin
        fill_val <= head;
        state <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_video_write_seq.sv
// tb_video_write_seq: directed scoreboard bench for video_write_seq
module tb_video_write_seq;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_fill = 0, data_valid = 0;
  logic [1:0] cmd_param = 0;
  logic [10:0] cmd_index = 0, cmd_count = 0;
  logic [15:0] data_val = 0;
  logic cmd_ready, data_ready, wen, busy, err;
  logic [1:0] w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;
  int cmp = 0, mism = 0, nwen = 0, nerr = 0, cyc = 0, first_c = -1, last_c = -1;
  logic [28:0] sb[$];
  logic [15:0] model[$];

  video_write_seq #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_param(cmd_param), .cmd_index(cmd_index), .cmd_count(cmd_count),
    .cmd_fill(cmd_fill), .data_valid(data_valid), .data_ready(data_ready),
    .data_val(data_val), .wen(wen), .w_param(w_param), .w_index(w_index),
    .w_val(w_val), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      nwen++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
      if (sb.size() == 0) chk("unexpected_wen", {3'd0, w_param, w_index, w_val}, 32'hFFFF_FFFF);
      else chk("write", {3'd0, w_param, w_index, w_val}, {3'd0, sb.pop_front()});
    end
    if (err) nerr++;
  end

  function automatic logic [10:0] lim(input logic [1:0] p);
    return p == 0 ? 11'd16 : p == 1 ? 11'd256 : 11'd1200;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nwen = 0; nerr = 0; first_c = -1; last_c = -1;
  endtask

  task automatic push_word(input logic [15:0] v);
    int t = 0;
    data_valid = 1; data_val = v;
    while (!data_ready && t < 100) begin step(); t++; end
    chk("push_timeout", t < 100, 1);
    step();
    data_valid = 0;
    model.push_back(v);
  endtask

  task automatic send_cmd(input logic [1:0] p, input logic [10:0] i, input logic [10:0] c,
                          input logic f, input bit use_model);
    int t = 0;
    logic [15:0] v;
    logic [10:0] ix;
    cmd_valid = 1; cmd_param = p; cmd_index = i; cmd_count = c; cmd_fill = f;
    while (!cmd_ready && t < 100) begin step(); t++; end
    chk("cmd_timeout", t < 100, 1);
    step();
    cmd_valid = 0;
    if (use_model && c != 0) begin
      if (f) v = model.pop_front();
      for (int k = 0; k < int'(c); k++) begin
        if (!f) v = model.pop_front();
        ix = i + 11'(k);
        if (ix < lim(p)) sb.push_back({p, ix, v});
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin step(); t++; end
    chk("idle_timeout", t < 5000, 1);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    reset = 0;
    step();
    chk("rst_wen", wen, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_data_ready", data_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_w", {w_param, w_index, w_val}, 0);
    // basic burst with prefilled FIFO
    clr();
    push_word(16'h0A0B); push_word(16'h0C0D); push_word(16'h0E0F); push_word(16'h0102);
    send_cmd(2, 100, 4, 0, 1);
    chk("t1_busy_during", busy, 1);
    wait_idle();
    chk("t1_nwen", nwen, 4);
    chk("t1_consecutive", last_c - first_c, 3);
    chk("t1_nerr", nerr, 0);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_busy_after", busy, 0);
    // clipping at paldef end
    clr();
    for (int k = 0; k < 4; k++) push_word(16'h1110 + 16'(k));
    send_cmd(0, 14, 4, 0, 1);
    wait_idle();
    chk("t2_nwen", nwen, 2);
    chk("t2_nerr", nerr, 1);
    chk("t2_sb_empty", sb.size(), 0);
    // fill whole tilemap
    clr();
    push_word(16'h0015);
    send_cmd(3, 0, 1200, 1, 1);
    wait_idle();
    chk("t3_nwen", nwen, 1200);
    chk("t3_consecutive", last_c - first_c, 1199);
    chk("t3_nerr", nerr, 0);
    chk("t3_sb_empty", sb.size(), 0);
    // trickled data
    clr();
    send_cmd(1, 0, 8, 0, 0);
    for (int k = 0; k < 8; k++) begin
      push_word(16'h0200 + 16'(k));
      sb.push_back({2'd1, 11'(k), model.pop_front()});
      step(); step();
    end
    wait_idle();
    chk("t4_nwen", nwen, 8);
    chk("t4_spacing", last_c - first_c, 21);
    chk("t4_nerr", nerr, 0);
    chk("t4_sb_empty", sb.size(), 0);
    // null command leaves FIFO untouched
    clr();
    push_word(16'h0777);
    send_cmd(2, 5, 0, 0, 1);
    chk("t5_cmd_ready", cmd_ready, 1);
    step(); step(); step();
    chk("t5_no_wen", nwen, 0);
    send_cmd(2, 6, 1, 0, 1);
    wait_idle();
    chk("t5_nwen", nwen, 1);
    chk("t5_sb_empty", sb.size(), 0);
    // index wrap: 2046 and 2047 clipped, 0 written, one err
    clr();
    for (int k = 0; k < 3; k++) push_word(16'h0400 + 16'(k));
    send_cmd(0, 2046, 3, 0, 1);
    wait_idle();
    chk("t6_nwen", nwen, 1);
    chk("t6_nerr", nerr, 1);
    chk("t6_sb_empty", sb.size(), 0);
    // full FIFO, then reset mid-burst
    clr();
    for (int k = 0; k < 8; k++) push_word(16'h0300 + 16'(k));
    chk("t7_full", data_ready, 0);
    data_valid = 1; data_val = 16'h0BAD;
    step(); step();
    chk("t7_still_full", data_ready, 0);
    data_valid = 0;
    send_cmd(2, 0, 5, 0, 0);
    sb.push_back({2'd2, 11'd0, model[0]});
    sb.push_back({2'd2, 11'd1, model[1]});
    model.delete();
    step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("t7_wen", wen, 0);
    chk("t7_cmd_ready", cmd_ready, 1);
    chk("t7_data_ready", data_ready, 1);
    chk("t7_busy", busy, 0);
    chk("t7_w", {w_param, w_index, w_val}, 0);
    step(); step(); step(); step(); step();
    chk("t7_nwen", nwen, 2);
    chk("t7_sb_empty", sb.size(), 0);
    clr();
    push_word(16'h0999);
    send_cmd(0, 3, 1, 0, 1);
    wait_idle();
    chk("t7_fifo_was_empty", nwen, 1);
    chk("t7_sb_empty2", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule

// File: doc/video_write_seq.md
# video_write_seq

Burst write sequencer directly upstream of the video tile/palette engine. It accepts a block-write command and a stream of 16-bit data words through valid/ready handshakes, buffers the words in a small FIFO, and drives the engine's write port (wen/w_param/w_index/w_val) at one write per cycle with auto-incrementing index. It clips writes to each table's size and supports a fill mode that replicates one word across a range.

## Interface
- FIFO_DEPTH, 8, data FIFO depth in words; power of two, at least 2
- clk  in  1  system clock, same clock as the video engine write port
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both are high at a rising edge
- cmd_param  in  2  target table: 0 paldef, 1 tiledef quarter-words, 2 palmap, 3 tilemap
- cmd_index  in  11  first index
- cmd_count  in  11  number of writes; 0 means a null command
- cmd_fill  in  1  1 = consume one data word and write it cmd_count times
- data_valid  in  1  data word present
- data_ready  out  1  FIFO not full
- data_val  in  16  data word
- wen  out  1  write strobe to video engine
- w_param  out  2  table select
- w_index  out  11  table index
- w_val  out  16  write value
- busy  out  1  command in progress
- err  out  1  one-cycle pulse on first clipped write of a command

## Operation
- Table limits (LIMIT): param 0 → 16, param 1 → 256, params 2 and 3 → 1200.
- Data FIFO:
  - Push when data_valid && data_ready.
  - data_ready = !full; it does not depend on pop.
  - Words may be pushed while idle; they wait for the next command.
- States: IDLE, BURST, FILL_LOAD, FILL.
- IDLE:
  - cmd_ready=1; all other states cmd_ready=0.
  - On accept, latch param, index, remaining=count and an internal clip flag=0.
  - count==0: stay IDLE; no write, no data consumed.
  - Otherwise go to BURST (fill=0) or FILL_LOAD (fill=1).
- BURST, each cycle with FIFO non-empty:
  - Pop the head word.
  - If index < LIMIT: register wen=1 and param/index/word.
  - Else: wen=0 (word discarded); if clip flag is 0, pulse err and set the flag.
  - index+=1, remaining-=1; remaining reaching 0 → IDLE.
  - FIFO empty: wen=0, hold state; no timeout.
- FILL_LOAD: when FIFO non-empty, pop one word into the fill register → FILL.
- FILL: one write per cycle from the fill register, with the same clipping, err and index/remaining rules as BURST; remaining reaching 0 → IDLE.
- busy = (state != IDLE).
- Index arithmetic is 11-bit:
  - index 2047 + 1 wraps to 0.
  - Wrapped indices below LIMIT are written normally.
  - The clip flag stays set, so err does not pulse again.

## Timing
- Command accepted at edge E: state leaves IDLE at E; first pop possible at edge E+1; first wen high in cycle after E+1.
- Data pushed at edge N is poppable at N+1 earliest; there is no fall-through.
- Sustained throughput is 1 write/cycle while the FIFO is non-empty.
- A count-k burst with a pre-filled FIFO gives exactly k consecutive cycles of wen (fewer if clipped).
- w_* outputs are registered and valid only while wen=1; they hold their last value otherwise.
- err is registered and aligned to the cycle the suppressed write would have appeared.
- After the last pop, state is IDLE. cmd_ready is high in the same cycle as the final wen, so back-to-back commands have a 1-cycle gap of wen=0.
- Reset (synchronous, any state):
  - State → IDLE, FIFO emptied, clip flag cleared.
  - wen=0, w_param=0, w_index=0, w_val=0, err=0, busy=0.
  - cmd_ready=1 and data_ready=1 in the first cycle after reset.
  - Reset mid-burst produces no further writes. A push coincident with the reset edge is dropped.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Test plan
- Pre-load 4 words 0x0A0B,0x0C0D,0x0E0F,0x0102; command param 2, index 100, count 4 → wen high 4 consecutive cycles at w_index 100..103, values in order, busy low after.
- Command param 0, index 14, count 4 with 4 words → writes at indices 14 and 15 only, single err pulse on index 16's slot, all 4 words consumed, FIFO empty.
- Fill command param 3, index 0, count 1200, one word 0x0015 → 1200 consecutive writes of 0x0015 to indices 0..1199, only one FIFO pop.
- Command param 1, index 0, count 8, data trickled one word every 3 cycles → 8 writes with wen gaps of 2 cycles, indices 0..7, no err.
- Push 9 words with FIFO_DEPTH=8 while idle → data_ready low after 8th push, 9th held by producer; reset asserted mid-burst of count 5 after 2 writes → no further wen, FIFO empty, cmd_ready=1.
- count=0 command → cmd_ready stays 1, no wen, FIFO occupancy unchanged.
